control_unit: RTL
=================

Name: control_unit

Overview:
- Hardwired control sequencer for the DataPath. It drives the same control lines the per-instruction benches drive by hand.
- Each instruction runs as fetch (T0–T2), then an opcode-specific execute sequence, then returns to T0.
- One control step per Clock rising edge.
- Sits beside DataPath: consumes IR and the CON FF output, produces every enable/out/select strobe.

Parameters:
ADD_OP, 5'b00011, ALU opcode driven for address/offset calculation.

Ports:
Clock  input  1  system clock, rising edge.
clr  input  1  asynchronous active-high reset.
IR  input  32  instruction register contents; opcode = IR[31:27].
CON_FF  input  1  branch condition flag from DataPath.
Stop  input  1  sampled in T0; 1 forces halt.
Run  output  1  1 while executing, 0 when halted.
PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out  output  1 each  bus-source selects.
PC_enable, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable  output  1 each  register loads.
IncPC, Read, RAM_write_enable, out_port_enable, con_in  output  1 each  misc strobes.
Gra, Grb, Grc, R_in, R_out  output  1 each  register-file select/enable.
opcode  output  5  ALU operation.

Behaviour:
- State: step register {T0..T7, HALT}. clr (async) forces T0 with Run=1.
- Outputs are combinational from step + IR[31:27]. Every strobe not listed below is 0, and opcode=0 unless given.
- While clr is high, all outputs are 0.
- Fetch:
  - T0: PC_out, MAR_enable, IncPC, PC_enable. If Stop=1, go to HALT instead of T1.
  - T1: Read, MDR_enable.
  - T2: MDR_out, IR_enable.
- Execute, by opcode (T3 onward); the last listed step returns to T0:
  - ALU reg (00011–01011 add,sub,and,or,ror,rol,shr,shra,shl):
    - T3 Grb,R_out,Y_enable
    - T4 Grc,R_out,opcode=IR op,Z_enable
    - T5 ZLow_out,Gra,R_in
  - ALU imm (01100–01110 addi,andi,ori):
    - T3 Grb,R_out,Y_enable
    - T4 C_out,opcode=IR op,Z_enable
    - T5 ZLow_out,Gra,R_in
  - ldi 00001: T3 Grb,BA_out,Y_enable; T4 C_out,opcode=ADD_OP,Z_enable; T5 ZLow_out,Gra,R_in.
  - ld 00000:
    - T3–T4 as ldi
    - T5 ZLow_out,MAR_enable
    - T6 Read,MDR_enable
    - T7 MDR_out,Gra,R_in
  - st 00010:
    - T3–T5 as ld
    - T6 Gra,R_out,MDR_enable (Read=0)
    - T7 RAM_write_enable
  - mul 10000 / div 01111:
    - T3 Gra,R_out,Y_enable
    - T4 Grb,R_out,opcode,Z_enable
    - T5 ZLow_out,LO_enable
    - T6 ZHigh_out,HI_enable
  - neg 10001 / not 10010: T3 Grb,R_out,opcode,Z_enable; T4 ZLow_out,Gra,R_in.
  - br 10011:
    - T3 Gra,R_out,con_in
    - T4 PC_out,Y_enable
    - T5 C_out,opcode=ADD_OP,Z_enable
    - T6 ZLow_out,PC_enable only if CON_FF=1; otherwise T6 drives nothing.
  - jr 10100: T3 Gra,R_out,PC_enable.
  - jal 10101: T3 PC_out,Grb,R_in (assembler encodes r15 in Rb); T4 Gra,R_out,PC_enable.
  - in 10110: T3 in_port_out,Gra,R_in.
  - out 10111: T3 Gra,R_out,out_port_enable.
  - mfhi 11000 / mflo 11001: T3 HI_out or LO_out,Gra,R_in.
  - nop 11010 and undefined opcodes (11100–11111): T3 drives nothing.
  - halt 11011: T3 drives nothing, then HALT.
- HALT: all strobes 0, Run=0. Held until clr.
- CON_FF is sampled combinationally in T6 only.
- clr mid-instruction aborts immediately. No partial write completes after clr deasserts; the next edge executes T0.
- IR is stable from T3 onward; its value in T0–T2 is ignored.

Test Plan:
- Reset then IR=add (00011) → T0..T5 over 6 edges; at T4 opcode=00011 with Grc,R_out,Z_enable; at T5 ZLow_out,Gra,R_in; back to T0.
- ld (00000): T5 MAR_enable+ZLow_out; T6 Read+MDR_enable; T7 MDR_out+Gra+R_in; 8 cycles total; st instead → T7 RAM_write_enable=1 and R_in never set.
- br with CON_FF=0 → T6 PC_enable=0; repeat with CON_FF=1 → T6 ZLow_out=PC_enable=1.
- jr → T3 Gra,R_out,PC_enable=1, then T0 next edge (4-cycle instruction); jal → T3 R_in with PC_out, T4 PC_enable.
- halt opcode 11011 → Run=0 after T3 and all outputs 0 for 20 cycles; clr pulse → Run=1, T0 strobes present.
- Assert clr asynchronously during ld T6 → outputs go 0 without waiting for the edge, Read drops; after release, the first edge shows T0 signals; Stop=1 in T0 → HALT.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired control sequencer for the DataPath.
// A step counter walks fetch (T0-T2) and an opcode-specific execute sequence,
// and the strobes are decoded combinationally from the step and IR[31:27].
module control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    // bus-source selects
    output logic        PC_out,
    output logic        ZHigh_out,
    output logic        ZLow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        C_out,
    output logic        MDR_out,
    output logic        in_port_out,
    output logic        BA_out,
    // register loads
    output logic        PC_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    // misc strobes
    output logic        IncPC,
    output logic        Read,
    output logic        RAM_write_enable,
    output logic        out_port_enable,
    output logic        con_in,
    // register-file select/enable
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic        R_out,
    output logic [4:0]  opcode
);

    // Instruction encodings (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } step_t;

    step_t step;
    step_t step_next;

    logic [4:0] op;
    logic       is_alu_reg;
    logic       is_alu_imm;
    logic       is_ldi;
    logic       is_ld;
    logic       is_st;
    logic       is_muldiv;
    logic       is_negnot;
    logic       is_br;
    logic       is_jr;
    logic       is_jal;
    logic       is_in;
    logic       is_out;
    logic       is_mfhi;
    logic       is_mflo;
    logic       is_halt;
    logic       unused_ir;

    assign op        = IR[31:27];
    // Only the opcode field steers the sequence; register/immediate fields go straight to the DataPath.
    assign unused_ir = ^IR[26:0];

    // Opcode classes; nop and the undefined codes fall through every class.
    assign is_alu_reg = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_alu_imm = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_ldi     = (op == OP_LDI);
    assign is_ld      = (op == OP_LD);
    assign is_st      = (op == OP_ST);
    assign is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
    assign is_negnot  = (op == OP_NEG) || (op == OP_NOT);
    assign is_br      = (op == OP_BR);
    assign is_jr      = (op == OP_JR);
    assign is_jal     = (op == OP_JAL);
    assign is_in      = (op == OP_IN);
    assign is_out     = (op == OP_OUT);
    assign is_mfhi    = (op == OP_MFHI);
    assign is_mflo    = (op == OP_MFLO);
    assign is_halt    = (op == OP_HALT);

    // Step register: clr restarts at T0, HALT holds until clr.
    always_ff @(posedge Clock or posedge clr) begin
        if (clr) begin
            step <= T0;
        end else begin
            step <= step_next;
        end
    end

    // Next-step and strobe decode; everything is silenced while clr is high.
    always_comb begin
        step_next        = T0;
        Run              = 1'b0;
        PC_out           = 1'b0;
        ZHigh_out        = 1'b0;
        ZLow_out         = 1'b0;
        HI_out           = 1'b0;
        LO_out           = 1'b0;
        C_out            = 1'b0;
        MDR_out          = 1'b0;
        in_port_out      = 1'b0;
        BA_out           = 1'b0;
        PC_enable        = 1'b0;
        MAR_enable       = 1'b0;
        MDR_enable       = 1'b0;
        IR_enable        = 1'b0;
        Y_enable         = 1'b0;
        Z_enable         = 1'b0;
        HI_enable        = 1'b0;
        LO_enable        = 1'b0;
        IncPC            = 1'b0;
        Read             = 1'b0;
        RAM_write_enable = 1'b0;
        out_port_enable  = 1'b0;
        con_in           = 1'b0;
        Gra              = 1'b0;
        Grb              = 1'b0;
        Grc              = 1'b0;
        R_in             = 1'b0;
        R_out            = 1'b0;
        opcode           = 5'b00000;

        if (!clr) begin
            Run = (step != HALT);
            case (step)
                T0: begin
                    PC_out     = 1'b1;
                    MAR_enable = 1'b1;
                    IncPC      = 1'b1;
                    PC_enable  = 1'b1;
                    step_next  = Stop ? HALT : T1;
                end
                T1: begin
                    Read       = 1'b1;
                    MDR_enable = 1'b1;
                    step_next  = T2;
                end
                T2: begin
                    MDR_out   = 1'b1;
                    IR_enable = 1'b1;
                    step_next = T3;
                end
                T3: begin
                    if (is_alu_reg || is_alu_imm) begin
                        Grb       = 1'b1;
                        R_out     = 1'b1;
                        Y_enable  = 1'b1;
                        step_next = T4;
                    end else if (is_ldi || is_ld || is_st) begin
                        // Base register, or zero when Rb is r0, into Y
                        Grb       = 1'b1;
                        BA_out    = 1'b1;
                        Y_enable  = 1'b1;
                        step_next = T4;
                    end else if (is_muldiv) begin
                        Gra       = 1'b1;
                        R_out     = 1'b1;
                        Y_enable  = 1'b1;
                        step_next = T4;
                    end else if (is_negnot) begin
                        Grb       = 1'b1;
                        R_out     = 1'b1;
                        opcode    = op;
                        Z_enable  = 1'b1;
                        step_next = T4;
                    end else if (is_br) begin
                        // Latch the branch condition against Ra
                        Gra       = 1'b1;
                        R_out     = 1'b1;
                        con_in    = 1'b1;
                        step_next = T4;
                    end else if (is_jr) begin
                        Gra       = 1'b1;
                        R_out     = 1'b1;
                        PC_enable = 1'b1;
                    end else if (is_jal) begin
                        // Link: return address into Rb (r15 by assembler convention)
                        PC_out    = 1'b1;
                        Grb       = 1'b1;
                        R_in      = 1'b1;
                        step_next = T4;
                    end else if (is_in) begin
                        in_port_out = 1'b1;
                        Gra         = 1'b1;
                        R_in        = 1'b1;
                    end else if (is_out) begin
                        Gra             = 1'b1;
                        R_out           = 1'b1;
                        out_port_enable = 1'b1;
                    end else if (is_mfhi) begin
                        HI_out = 1'b1;
                        Gra    = 1'b1;
                        R_in   = 1'b1;
                    end else if (is_mflo) begin
                        LO_out = 1'b1;
                        Gra    = 1'b1;
                        R_in   = 1'b1;
                    end else if (is_halt) begin
                        step_next = HALT;
                    end
                end
                T4: begin
                    if (is_alu_reg) begin
                        Grc       = 1'b1;
                        R_out     = 1'b1;
                        opcode    = op;
                        Z_enable  = 1'b1;
                        step_next = T5;
                    end else if (is_alu_imm) begin
                        C_out     = 1'b1;
                        opcode    = op;
                        Z_enable  = 1'b1;
                        step_next = T5;
                    end else if (is_ldi || is_ld || is_st) begin
                        // Effective address / immediate = Y + C
                        C_out     = 1'b1;
                        opcode    = ADD_OP;
                        Z_enable  = 1'b1;
                        step_next = T5;
                    end else if (is_muldiv) begin
                        Grb       = 1'b1;
                        R_out     = 1'b1;
                        opcode    = op;
                        Z_enable  = 1'b1;
                        step_next = T5;
                    end else if (is_negnot) begin
                        ZLow_out = 1'b1;
                        Gra      = 1'b1;
                        R_in     = 1'b1;
                    end else if (is_br) begin
                        PC_out    = 1'b1;
                        Y_enable  = 1'b1;
                        step_next = T5;
                    end else if (is_jal) begin
                        Gra       = 1'b1;
                        R_out     = 1'b1;
                        PC_enable = 1'b1;
                    end
                end
                T5: begin
                    if (is_alu_reg || is_alu_imm || is_ldi) begin
                        ZLow_out = 1'b1;
                        Gra      = 1'b1;
                        R_in     = 1'b1;
                    end else if (is_ld || is_st) begin
                        ZLow_out   = 1'b1;
                        MAR_enable = 1'b1;
                        step_next  = T6;
                    end else if (is_muldiv) begin
                        ZLow_out  = 1'b1;
                        LO_enable = 1'b1;
                        step_next = T6;
                    end else if (is_br) begin
                        // Branch target = PC + C
                        C_out     = 1'b1;
                        opcode    = ADD_OP;
                        Z_enable  = 1'b1;
                        step_next = T6;
                    end
                end
                T6: begin
                    if (is_ld) begin
                        Read       = 1'b1;
                        MDR_enable = 1'b1;
                        step_next  = T7;
                    end else if (is_st) begin
                        // Store data comes from Ra over the bus, not from memory
                        Gra        = 1'b1;
                        R_out      = 1'b1;
                        MDR_enable = 1'b1;
                        step_next  = T7;
                    end else if (is_muldiv) begin
                        ZHigh_out = 1'b1;
                        HI_enable = 1'b1;
                    end else if (is_br) begin
                        // Taken branch only commits the target when the condition held
                        if (CON_FF) begin
                            ZLow_out  = 1'b1;
                            PC_enable = 1'b1;
                        end
                    end
                end
                T7: begin
                    if (is_ld) begin
                        MDR_out = 1'b1;
                        Gra     = 1'b1;
                        R_in    = 1'b1;
                    end else if (is_st) begin
                        RAM_write_enable = 1'b1;
                    end
                end
                HALT: begin
                    step_next = HALT;
                end
                default: begin
                    step_next = T0;
                end
            endcase
        end
    end

endmodule
